xgmii_link_status: RTL and testbench



---
 rtl/xgmii_link_status_pkg.sv | 63 ++++++
 rtl/xgmii_lfs_decode.sv | 31 +++
 rtl/xgmii_link_status.sv | 122 ++++++++++++
 tb/tb_xgmii_link_status.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_link_status_pkg.sv
// Shared XGMII control characters, fault-state types and the per-column
// link-fault sequence update used by the link status monitor.
package xgmii_link_status_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_SEQ   = 8'h9C;
  localparam logic [7:0] LFS_LOCAL   = 8'h01;
  localparam logic [7:0] LFS_REMOTE  = 8'h02;

  localparam int SEQ_CNT_MAX = 4;
  localparam int COL_CNT_MAX = 128;

  typedef enum logic {
    SEQ_LOCAL  = 1'b0,
    SEQ_REMOTE = 1'b1
  } seq_type_t;

  typedef struct packed {
    seq_type_t   seq_type;
    logic [2:0]  seq_cnt;
    logic [7:0]  col_cnt;
    logic        local_fault;
    logic        remote_fault;
  } fault_state_t;

  // One 4-lane column of the fault sequence machine; column 1 chains off
  // column 0's result so both columns of a word resolve in one cycle.
  function automatic fault_state_t step_column(input fault_state_t cur,
                                               input logic         is_seq,
                                               input seq_type_t    typ);
    fault_state_t nxt;
    nxt = cur;
    if (is_seq) begin
      if ((cur.seq_cnt != 3'd0) && (typ == cur.seq_type) &&
          (cur.col_cnt < 8'(COL_CNT_MAX))) begin
        if (cur.seq_cnt < 3'(SEQ_CNT_MAX)) begin
          nxt.seq_cnt = cur.seq_cnt + 3'd1;
        end
      end else begin
        nxt.seq_type = typ;
        nxt.seq_cnt  = 3'd1;
      end
      nxt.col_cnt = 8'd0;
      if (nxt.seq_cnt == 3'(SEQ_CNT_MAX)) begin
        nxt.local_fault  = (typ == SEQ_LOCAL);
        nxt.remote_fault = (typ == SEQ_REMOTE);
      end
    end else begin
      if (cur.col_cnt < 8'(COL_CNT_MAX)) begin
        nxt.col_cnt = cur.col_cnt + 8'd1;
      end
      if (nxt.col_cnt == 8'(COL_CNT_MAX)) begin
        nxt.seq_cnt      = 3'd0;
        nxt.local_fault  = 1'b0;
        nxt.remote_fault = 1'b0;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/xgmii_lfs_decode.sv
// Combinational classifier for one 32-bit XGMII column: link-fault
// sequence ordered set (and its type) or column-aligned start.
module xgmii_lfs_decode
  import xgmii_link_status_pkg::*;
(
  input  logic [31:0] col,
  input  logic [3:0]  ctrl,
  output logic        is_seq,
  output seq_type_t   seq_type,
  output logic        is_start
);

  logic [7:0] lane0;
  logic [7:0] lane1;
  logic [7:0] lane2;
  logic [7:0] lane3;

  assign lane0 = col[7:0];
  assign lane1 = col[15:8];
  assign lane2 = col[23:16];
  assign lane3 = col[31:24];

  always_comb begin
    is_seq   = (ctrl == 4'b0001) && (lane0 == XGMII_SEQ) &&
               (lane1 == 8'h00) && (lane2 == 8'h00) &&
               ((lane3 == LFS_LOCAL) || (lane3 == LFS_REMOTE));
    seq_type = (lane3 == LFS_REMOTE) ? SEQ_REMOTE : SEQ_LOCAL;
    is_start = ctrl[0] && (lane0 == XGMII_START);
  end

endmodule

// File: rtl/xgmii_link_status.sv
// Per-port 10GBASE-R receive link monitor: link-fault detection, link-up
// hold-off, frame-start counting and stretched activity for the SFP LEDs.
module xgmii_link_status
  import xgmii_link_status_pkg::*;
#(
  parameter int LINK_UP_CYCLES = 1024,
  parameter int ACT_CYCLES     = 1048576,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            xgmii_rxd,
  input  logic [7:0]             xgmii_rxc,
  input  logic                   rx_block_lock,
  output logic                   link_up,
  output logic                   local_fault,
  output logic                   remote_fault,
  output logic                   rx_activity,
  output logic [COUNT_WIDTH-1:0] rx_frame_count,
  output logic [1:0]             led
);

  localparam int LINK_W = $clog2(LINK_UP_CYCLES + 1);
  localparam int ACT_W  = $clog2(ACT_CYCLES + 1);

  localparam fault_state_t FAULT_RESET = '{
    seq_type:     SEQ_LOCAL,
    seq_cnt:      3'd0,
    col_cnt:      8'd0,
    local_fault:  1'b1,
    remote_fault: 1'b0
  };

  logic      is_seq0;
  logic      is_seq1;
  logic      is_start0;
  logic      is_start1;
  seq_type_t seq_type0;
  seq_type_t seq_type1;

  xgmii_lfs_decode u_dec_col0 (
    .col      (xgmii_rxd[31:0]),
    .ctrl     (xgmii_rxc[3:0]),
    .is_seq   (is_seq0),
    .seq_type (seq_type0),
    .is_start (is_start0)
  );

  xgmii_lfs_decode u_dec_col1 (
    .col      (xgmii_rxd[63:32]),
    .ctrl     (xgmii_rxc[7:4]),
    .is_seq   (is_seq1),
    .seq_type (seq_type1),
    .is_start (is_start1)
  );

  fault_state_t            fs;
  fault_state_t            fs_mid;
  fault_state_t            fs_next;
  logic [LINK_W-1:0]       link_cnt;
  logic [LINK_W-1:0]       link_cnt_next;
  logic [ACT_W-1:0]        act_cnt;
  logic [ACT_W-1:0]        act_cnt_next;
  logic [COUNT_WIDTH-1:0]  frame_cnt_next;
  logic                    clean;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs             <= FAULT_RESET;
      link_cnt       <= '0;
      link_up        <= 1'b0;
      act_cnt        <= '0;
      rx_activity    <= 1'b0;
      rx_frame_count <= '0;
    end else begin
      fs             <= fs_next;
      link_cnt       <= link_cnt_next;
      link_up        <= (link_cnt_next == LINK_W'(LINK_UP_CYCLES));
      act_cnt        <= act_cnt_next;
      rx_activity    <= (act_cnt_next != '0);
      rx_frame_count <= frame_cnt_next;
    end
  end

  // Loss of block lock forces a local fault and restarts both the gap
  // count and the hold-off, regardless of what the columns carried.
  always_comb begin
    fs_mid  = step_column(fs, is_seq0, seq_type0);
    fs_next = step_column(fs_mid, is_seq1, seq_type1);
    if (!rx_block_lock) begin
      fs_next.seq_cnt      = 3'd0;
      fs_next.col_cnt      = 8'd0;
      fs_next.local_fault  = 1'b1;
      fs_next.remote_fault = 1'b0;
    end

    clean = rx_block_lock && !fs_next.local_fault && !fs_next.remote_fault;
    link_cnt_next = '0;
    if (clean) begin
      if (link_cnt == LINK_W'(LINK_UP_CYCLES)) begin
        link_cnt_next = link_cnt;
      end else begin
        link_cnt_next = link_cnt + LINK_W'(1);
      end
    end

    act_cnt_next = act_cnt;
    if (is_start0 || is_start1) begin
      act_cnt_next = ACT_W'(ACT_CYCLES);
    end else if (act_cnt != '0) begin
      act_cnt_next = act_cnt - ACT_W'(1);
    end

    frame_cnt_next = rx_frame_count + COUNT_WIDTH'(is_start0)
                                    + COUNT_WIDTH'(is_start1);
  end

  assign local_fault  = fs.local_fault;
  assign remote_fault = fs.remote_fault;
  assign led          = {rx_activity, link_up};

endmodule

// File: tb/tb_xgmii_link_status.sv
// Self-checking bench for xgmii_link_status: a column-level reference model
// feeds a scoreboard, and each scenario task adds targeted checks.
module tb_xgmii_link_status;
  import xgmii_link_status_pkg::*;

  localparam int LINK_N = 16;
  localparam int ACT_N  = 8;

  localparam logic [31:0] IDLE_COL = {4{XGMII_IDLE}};
  localparam logic [31:0] LOC_COL  = {LFS_LOCAL, 8'h00, 8'h00, XGMII_SEQ};
  localparam logic [31:0] REM_COL  = {LFS_REMOTE, 8'h00, 8'h00, XGMII_SEQ};
  localparam logic [63:0] IDLE_W   = {IDLE_COL, IDLE_COL};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] xgmii_rxd = IDLE_W;
  logic [7:0]  xgmii_rxc = 8'hFF;
  logic        rx_block_lock = 1'b1;
  logic        link_up;
  logic        local_fault;
  logic        remote_fault;
  logic        rx_activity;
  logic [31:0] rx_frame_count;
  logic [1:0]  led;

  xgmii_link_status #(
    .LINK_UP_CYCLES (LINK_N),
    .ACT_CYCLES     (ACT_N),
    .COUNT_WIDTH    (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .xgmii_rxd      (xgmii_rxd),
    .xgmii_rxc      (xgmii_rxc),
    .rx_block_lock  (rx_block_lock),
    .link_up        (link_up),
    .local_fault    (local_fault),
    .remote_fault   (remote_fault),
    .rx_activity    (rx_activity),
    .rx_frame_count (rx_frame_count),
    .led            (led)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        lu;
    logic        lf;
    logic        rf;
    logic        act;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state
  int          m_type, m_seq, m_col, m_link, m_act;
  logic        m_lf, m_rf;
  logic [31:0] m_cnt;
  int          m_starts;

  logic [31:0] col_d;
  logic [3:0]  col_c;
  bit          col_half = 1'b0;

  task automatic model_reset();
    m_type = 0; m_seq = 0; m_col = 0; m_link = 0; m_act = 0;
    m_lf = 1'b1; m_rf = 1'b0; m_cnt = 32'd0;
  endtask

  task automatic model_column(input logic [31:0] d, input logic [3:0] c);
    int t;
    if (c[0] && d[7:0] == 8'hFB) m_starts++;
    if (c == 4'b0001 && d[7:0] == 8'h9C && d[23:8] == 16'h0000 &&
        (d[31:24] == 8'h01 || d[31:24] == 8'h02)) begin
      t = (d[31:24] == 8'h02) ? 1 : 0;
      if (m_seq != 0 && t == m_type && m_col < 128) begin
        if (m_seq < 4) m_seq++;
      end else begin
        m_type = t;
        m_seq = 1;
      end
      m_col = 0;
      if (m_seq == 4) begin
        m_lf = (t == 0);
        m_rf = (t == 1);
      end
    end else begin
      if (m_col < 128) m_col++;
      if (m_col == 128) begin
        m_seq = 0; m_lf = 1'b0; m_rf = 1'b0;
      end
    end
  endtask

  task automatic drive_word(input logic [63:0] d, input logic [7:0] c, input logic lock);
    exp_t e;
    xgmii_rxd = d;
    xgmii_rxc = c;
    rx_block_lock = lock;
    m_starts = 0;
    model_column(d[31:0], c[3:0]);
    model_column(d[63:32], c[7:4]);
    if (!lock) begin
      m_lf = 1'b1; m_rf = 1'b0; m_seq = 0; m_col = 0;
    end
    if (lock && !m_lf && !m_rf) m_link = (m_link < LINK_N) ? m_link + 1 : LINK_N;
    else m_link = 0;
    m_cnt = m_cnt + 32'(m_starts);
    if (m_starts != 0) m_act = ACT_N;
    else if (m_act > 0) m_act--;
    e.lu = (m_link == LINK_N);
    e.lf = m_lf;
    e.rf = m_rf;
    e.act = (m_act != 0);
    e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic push_col(input logic [31:0] d, input logic [3:0] c);
    if (!col_half) begin
      col_d = d; col_c = c; col_half = 1'b1;
    end else begin
      col_half = 1'b0;
      drive_word({d, col_d}, {c, col_c}, 1'b1);
    end
  endtask

  task automatic idle_words(input int n);
    for (int i = 0; i < n; i++) drive_word(IDLE_W, 8'hFF, 1'b1);
  endtask

  // Scoreboard: one expectation per driven word, checked 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      tests_run++;
      if (link_up !== mon_e.lu || local_fault !== mon_e.lf || remote_fault !== mon_e.rf ||
          rx_activity !== mon_e.act || rx_frame_count !== mon_e.cnt ||
          led !== {mon_e.act, mon_e.lu}) begin
        tests_failed++;
        $display("[TB] FAIL scoreboard t=%0t got lu=%b lf=%b rf=%b act=%b cnt=%0d led=%b expected lu=%b lf=%b rf=%b act=%b cnt=%0d",
                 $time, link_up, local_fault, remote_fault, rx_activity, rx_frame_count, led,
                 mon_e.lu, mon_e.lf, mon_e.rf, mon_e.act, mon_e.cnt);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if ({link_up, local_fault, remote_fault, rx_activity, led} !== 6'b010000 || rx_frame_count !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values got lu=%b lf=%b rf=%b act=%b led=%b cnt=%0d expected lu=0 lf=1 rf=0 act=0 led=00 cnt=0",
               link_up, local_fault, remote_fault, rx_activity, led, rx_frame_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back_local();
    drive_word({LOC_COL, LOC_COL}, 8'h11, 1'b1);
    drive_word({LOC_COL, LOC_COL}, 8'h11, 1'b1);
    tests_run++;
    if (local_fault !== 1'b1 || link_up !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_local_declare got lf=%b lu=%b expected lf=1 lu=0", local_fault, link_up);
    end
    idle_words(63);
    tests_run++;
    if (local_fault !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_local_hold_63 got lf=%b expected 1", local_fault);
    end
    idle_words(1);
    tests_run++;
    if (local_fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_local_clear_64 got lf=%b expected 0", local_fault);
    end
    idle_words(14);
    tests_run++;
    if (link_up !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL holdoff_early got lu=%b expected 0", link_up);
    end
    idle_words(1);
    tests_run++;
    if (link_up !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL holdoff_rise got lu=%b expected 1", link_up);
    end
  endtask

  task automatic test_type_switch();
    drive_word({LOC_COL, LOC_COL}, 8'h11, 1'b1);
    drive_word({REM_COL, REM_COL}, 8'h11, 1'b1);
    tests_run++;
    if (remote_fault !== 1'b0 || local_fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL type_switch_mid got lf=%b rf=%b expected lf=0 rf=0", local_fault, remote_fault);
    end
    drive_word({REM_COL, REM_COL}, 8'h11, 1'b1);
    tests_run++;
    if (remote_fault !== 1'b1 || local_fault !== 1'b0 || link_up !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL type_switch_remote got lf=%b rf=%b lu=%b expected lf=0 rf=1 lu=0",
               local_fault, remote_fault, link_up);
    end
    idle_words(64);
    tests_run++;
    if (remote_fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL type_switch_clear got rf=%b expected 0", remote_fault);
    end
  endtask

  task automatic test_gap_limit();
    bit saw_rf;
    push_col(REM_COL, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 127; i++) push_col(IDLE_COL, 4'hF);
      push_col(REM_COL, 4'b0001);
    end
    push_col(IDLE_COL, 4'hF);
    tests_run++;
    if (remote_fault !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL gap_127 got rf=%b expected 1", remote_fault);
    end
    idle_words(64);
    saw_rf = 1'b0;
    push_col(REM_COL, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 128; i++) begin
        push_col(IDLE_COL, 4'hF);
        if (remote_fault === 1'b1) saw_rf = 1'b1;
      end
      push_col(REM_COL, 4'b0001);
      if (remote_fault === 1'b1) saw_rf = 1'b1;
    end
    tests_run++;
    if (saw_rf !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL gap_128 got rf_seen=%b expected 0", saw_rf);
    end
  endtask

  task automatic test_link_holdoff();
    idle_words(80);
    tests_run++;
    if (link_up !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL holdoff_settled got lu=%b expected 1", link_up);
    end
    drive_word(IDLE_W, 8'hFF, 1'b0);
    tests_run++;
    if (link_up !== 1'b0 || local_fault !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL lock_drop got lu=%b lf=%b expected lu=0 lf=1", link_up, local_fault);
    end
    idle_words(64 + 14);
    tests_run++;
    if (link_up !== 1'b0 || local_fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL relock_early got lu=%b lf=%b expected lu=0 lf=0", link_up, local_fault);
    end
    idle_words(1);
    tests_run++;
    if (link_up !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL relock_rise got lu=%b expected 1", link_up);
    end
  endtask

  task automatic test_frame_count();
    drive_word(64'h070707FB_070707FB, 8'hFF, 1'b1);
    tests_run++;
    if (rx_frame_count !== 32'd2 || rx_activity !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL dual_start got cnt=%0d act=%b expected cnt=2 act=1", rx_frame_count, rx_activity);
    end
    idle_words(7);
    tests_run++;
    if (rx_activity !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL act_stretch got act=%b expected 1", rx_activity);
    end
    idle_words(1);
    tests_run++;
    if (rx_activity !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL act_expire got act=%b expected 0", rx_activity);
    end
    drive_word(64'h07070707_07FB0707, 8'hFF, 1'b1);
    tests_run++;
    if (rx_frame_count !== 32'd2 || rx_activity !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lane2_start got cnt=%0d act=%b expected cnt=2 act=0", rx_frame_count, rx_activity);
    end
    drive_word(64'h070707FB_07070707, 8'hFF, 1'b1);
    drive_word(64'h070707FB_070707FB, 8'hFF, 1'b1);
    tests_run++;
    if (rx_frame_count !== 32'd5) begin
      tests_failed++;
      $display("[TB] FAIL count_five got cnt=%0d expected 5", rx_frame_count);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({link_up, local_fault, remote_fault, rx_activity, led} !== 6'b010000 || rx_frame_count !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got lu=%b lf=%b rf=%b act=%b led=%b cnt=%0d expected lu=0 lf=1 rf=0 act=0 led=00 cnt=0",
               link_up, local_fault, remote_fault, rx_activity, led, rx_frame_count);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive_word(64'h07070707_070707FB, 8'hFF, 1'b1);
    tests_run++;
    if (rx_frame_count !== 32'd1 || local_fault !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL count_restart got cnt=%0d lf=%b expected cnt=1 lf=1", rx_frame_count, local_fault);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_back_to_back_local();
    test_type_switch();
    test_gap_limit();
    test_link_holdoff();
    test_frame_count();
    test_reset_mid();
    #3;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
